// File: rtl/softmax_pkg.sv
// -----------------------------------------------------------------------------
// softmax_pkg
// Shared constants and types for the softmax datapath blocks.
//   DATAWIDTH : lane width of the fixed-point scores
//   NUM       : lanes per beat
//   NEG_MAX   : most negative DATAWIDTH-bit two's-complement value, used as
//               the identity element of a running signed max
//   state_e   : row-level FSM states of the max-reduction unit
// -----------------------------------------------------------------------------
package softmax_pkg;

    localparam int DATAWIDTH = 16;
    localparam int NUM       = 4;

    localparam logic [15:0] NEG_MAX = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/softmax_max_reduce_max4_tree.sv
// -----------------------------------------------------------------------------
// max4_tree
// Combinational signed maximum of four lanes plus the index of the winning
// lane. Ties always resolve to the lowest lane number, because a higher lane
// only wins when it is strictly greater.
// Ports:
//   a0..a3   : lane values, two's-complement signed
//   max_val  : largest of the four lanes
//   max_lane : lane index (0..3) of max_val
// -----------------------------------------------------------------------------
module max4_tree
    import softmax_pkg::*;
#(
    parameter int DATAWIDTH = 16
) (
    input  logic [DATAWIDTH-1:0] a0,
    input  logic [DATAWIDTH-1:0] a1,
    input  logic [DATAWIDTH-1:0] a2,
    input  logic [DATAWIDTH-1:0] a3,
    output logic [DATAWIDTH-1:0] max_val,
    output logic [1:0]           max_lane
);

    logic [DATAWIDTH-1:0] lo_max_s;
    logic [DATAWIDTH-1:0] hi_max_s;
    logic [1:0]           lo_idx_s;
    logic [1:0]           hi_idx_s;

    // Pairwise compare of lanes 0/1 and 2/3, then a final compare of the pairs.
    always_comb begin
        lo_max_s = a0;
        lo_idx_s = 2'd0;
        hi_max_s = a2;
        hi_idx_s = 2'd2;
        max_val  = a0;
        max_lane = 2'd0;

        if ($signed(a1) > $signed(a0)) begin
            lo_max_s = a1;
            lo_idx_s = 2'd1;
        end else begin
            lo_max_s = a0;
            lo_idx_s = 2'd0;
        end

        if ($signed(a3) > $signed(a2)) begin
            hi_max_s = a3;
            hi_idx_s = 2'd3;
        end else begin
            hi_max_s = a2;
            hi_idx_s = 2'd2;
        end

        // The upper pair must be strictly greater to beat the lower lanes.
        if ($signed(hi_max_s) > $signed(lo_max_s)) begin
            max_val  = hi_max_s;
            max_lane = hi_idx_s;
        end else begin
            max_val  = lo_max_s;
            max_lane = lo_idx_s;
        end
    end

endmodule

// File: rtl/softmax_max_reduce.sv
// -----------------------------------------------------------------------------
// softmax_max_reduce
// Streaming signed max-reduction over a row of scores, four lanes per beat.
// The row maximum is the scalar subtracted from every score by the downstream
// subtract stage.
//
// Pipeline: stage 1 registers the per-beat max (max4_tree), stage 2 folds it
// into the running row max. After the last beat one DRAIN cycle lets stage 2
// absorb the final stage-1 result before the result is offered in DONE.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, len      : row request (sampled only in IDLE) and beat count
//   in_valid        : lane data valid
//   in_ready        : a beat is accepted when in_valid & in_ready
//   a_inp0..a_inp3  : lane scores
//   max_valid       : row result available (DONE)
//   max_ready       : consumer takes the result
//   max_out         : row maximum, held until the next start
//   max_idx         : flat index beat*4+lane of the maximum
//                     (only with MAX_REDUCE_ARGMAX_EN)
//
// Build option: define MAX_REDUCE_ARGMAX_EN to add the max_idx port and the
// index tracking registers. max_out timing is the same either way.
// -----------------------------------------------------------------------------
module softmax_max_reduce
    import softmax_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int NUM       = 4,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a_inp0,
    input  logic [DATAWIDTH-1:0] a_inp1,
    input  logic [DATAWIDTH-1:0] a_inp2,
    input  logic [DATAWIDTH-1:0] a_inp3,
    output logic                 max_valid,
    input  logic                 max_ready,
`ifdef MAX_REDUCE_ARGMAX_EN
    output logic [DATAWIDTH-1:0] max_out,
    output logic [LEN_W+1:0]     max_idx
`else
    output logic [DATAWIDTH-1:0] max_out
`endif
);

    localparam int LANE_W = $clog2(NUM);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [DATAWIDTH-1:0] NEG_MAX_C = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [LEN_W-1:0]     LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]     LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [LEN_W-1:0]     beat_cnt_r;
    logic                 in_ready_r;
    logic                 max_valid_r;

    logic                 start_ok_s;
    logic                 accept_s;
    logic                 last_beat_s;
    logic                 done_hs_s;

    logic [DATAWIDTH-1:0] tree_max_s;
    logic                 s1_valid_r;
    logic [DATAWIDTH-1:0] s1_max_r;
    logic [DATAWIDTH-1:0] run_max_r;
    logic                 s2_update_s;

`ifdef MAX_REDUCE_ARGMAX_EN
    logic [LANE_W-1:0]    tree_lane_s;
    logic [LEN_W-1:0]     beat_num_r;
    logic [LEN_W-1:0]     s1_beat_r;
    logic [LANE_W-1:0]    s1_lane_r;
    logic [LEN_W+LANE_W-1:0] run_idx_r;
`else
    logic [1:0]           tree_lane_unused_s;
`endif

    assign start_ok_s  = start & (state_r == ST_IDLE);
    assign accept_s    = in_valid & in_ready_r;
    assign last_beat_s = accept_s & (beat_cnt_r == LEN_ONE);
    assign done_hs_s   = max_valid_r & max_ready;
    assign s2_update_s = s1_valid_r & ($signed(s1_max_r) > $signed(run_max_r));

    assign in_ready  = in_ready_r;
    assign max_valid = max_valid_r;
    assign max_out   = run_max_r;

    max4_tree #(
        .DATAWIDTH (DATAWIDTH)
    ) u_stage1_tree (
        .a0       (a_inp0),
        .a1       (a_inp1),
        .a2       (a_inp2),
        .a3       (a_inp3),
        .max_val  (tree_max_s),
`ifdef MAX_REDUCE_ARGMAX_EN
        .max_lane (tree_lane_s)
`else
        .max_lane (tree_lane_unused_s)
`endif
    );

    // Row FSM next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == LEN_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (done_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, registered handshake outputs and remaining-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            max_valid_r <= 1'b0;
            beat_cnt_r  <= LEN_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            // Decoded from the next state so the flags line up with state_r.
            in_ready_r  <= (state_nxt_s == ST_ACCUM);
            max_valid_r <= (state_nxt_s == ST_DONE);
            if (start_ok_s) begin
                beat_cnt_r <= len;
            end else if (accept_s) begin
                beat_cnt_r <= beat_cnt_r - LEN_ONE;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    // Stage 1: capture the per-beat max of an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_max_r   <= NEG_MAX_C;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_max_r <= tree_max_s;
            end else begin
                s1_max_r <= s1_max_r;
            end
        end
    end

    // Stage 2: running row max; strict compare keeps the earliest beat on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max_r <= NEG_MAX_C;
        end else begin
            if (start_ok_s) begin
                run_max_r <= NEG_MAX_C;
            end else if (s2_update_s) begin
                run_max_r <= s1_max_r;
            end else begin
                run_max_r <= run_max_r;
            end
        end
    end

`ifdef MAX_REDUCE_ARGMAX_EN
    assign max_idx = run_idx_r;

    // Beat number of the next beat to be accepted within the current row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_num_r <= LEN_ZERO;
        end else begin
            if (start_ok_s) begin
                beat_num_r <= LEN_ZERO;
            end else if (accept_s) begin
                beat_num_r <= beat_num_r + LEN_ONE;
            end else begin
                beat_num_r <= beat_num_r;
            end
        end
    end

    // Stage 1 index: beat number and winning lane travel with s1_max_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_beat_r <= LEN_ZERO;
            s1_lane_r <= {LANE_W{1'b0}};
        end else begin
            if (accept_s) begin
                s1_beat_r <= beat_num_r;
                s1_lane_r <= tree_lane_s;
            end else begin
                s1_beat_r <= s1_beat_r;
                s1_lane_r <= s1_lane_r;
            end
        end
    end

    // Stage 2 index: flat beat*4+lane, updated together with run_max_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_idx_r <= {(LEN_W+LANE_W){1'b0}};
        end else begin
            if (start_ok_s) begin
                run_idx_r <= {(LEN_W+LANE_W){1'b0}};
            end else if (s2_update_s) begin
                run_idx_r <= {s1_beat_r, s1_lane_r};
            end else begin
                run_idx_r <= run_idx_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_softmax_max_reduce.sv
// -----------------------------------------------------------------------------
// tb_softmax_max_reduce
// Directed self-checking bench for softmax_max_reduce. Each scenario task
// drives its own rows and compares against hand-computed results.
// -----------------------------------------------------------------------------
module tb_softmax_max_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_inp0;
    logic [15:0] a_inp1;
    logic [15:0] a_inp2;
    logic [15:0] a_inp3;
    logic        max_valid;
    logic        max_ready;
    logic [15:0] max_out;
`ifdef MAX_REDUCE_ARGMAX_EN
    logic [9:0]  max_idx;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    softmax_max_reduce #(
        .DATAWIDTH (16),
        .NUM       (4),
        .LEN_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_inp0    (a_inp0),
        .a_inp1    (a_inp1),
        .a_inp2    (a_inp2),
        .a_inp3    (a_inp3),
        .max_valid (max_valid),
        .max_ready (max_ready),
`ifdef MAX_REDUCE_ARGMAX_EN
        .max_out   (max_out),
        .max_idx   (max_idx)
`else
        .max_out   (max_out)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic beat(input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2, input logic [15:0] v3);
        a_inp0   = v0;
        a_inp1   = v1;
        a_inp2   = v2;
        a_inp3   = v3;
        in_valid = 1'b1;
        for (int t = 0; t < 8 && in_ready !== 1'b1; t++) tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL beat_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for the row result, compare it, handshake it and confirm it holds.
    task automatic wait_result(input string nm, input logic [15:0] exp_max,
                               input logic [9:0] exp_idx);
        for (int t = 0; t < 8 && max_valid !== 1'b1; t++) tick();
        n_tests++;
        if (max_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: max_valid=%b expected 1", nm, max_valid);
        end
        n_tests++;
        if (max_out !== exp_max) begin
            n_fail++;
            $display("FAIL %s_max: max_out=%h expected %h (argmax %0d)", nm, max_out, exp_max, exp_idx);
        end
`ifdef MAX_REDUCE_ARGMAX_EN
        n_tests++;
        if (max_idx !== exp_idx) begin
            n_fail++;
            $display("FAIL %s_idx: max_idx=%0d expected %0d", nm, max_idx, exp_idx);
        end
`endif
        max_ready = 1'b1;
        tick();
        max_ready = 1'b0;
        n_tests++;
        if (max_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hs: max_valid=%b expected 0 after handshake", nm, max_valid);
        end
        n_tests++;
        if (max_out !== exp_max) begin
            n_fail++;
            $display("FAIL %s_hold: max_out=%h expected %h in IDLE", nm, max_out, exp_max);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        max_ready = 1'b0;
        a_inp0    = 16'h0000;
        a_inp1    = 16'h0000;
        a_inp2    = 16'h0000;
        a_inp3    = 16'h0000;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0 || max_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: in_ready=%b max_valid=%b expected 0 0", in_ready, max_valid);
        end
        n_tests++;
        if (max_out !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_max: max_out=%h expected 8000", max_out);
        end
`ifdef MAX_REDUCE_ARGMAX_EN
        n_tests++;
        if (max_idx !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_idx: max_idx=%0d expected 0", max_idx);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_start(8'd2);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: in_ready=%b expected 1 after start", in_ready);
        end
        beat(16'h0001, 16'h0005, 16'h0003, 16'h0002);
        beat(16'h0004, 16'h0000, 16'h0007, 16'h0006);
        // One edge after the last beat: DRAIN, nothing offered yet.
        n_tests++;
        if (max_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: max_valid=%b in_ready=%b expected 0 0", max_valid, in_ready);
        end
        tick();
        n_tests++;
        if (max_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: max_valid=%b expected 1 two cycles after last beat", max_valid);
        end
        wait_result("basic", 16'h0007, 10'd6);
    endtask

    task automatic test_all_negative();
        do_start(8'd1);
        beat(16'hFFF0, 16'hFF00, 16'hFFFF, 16'h8001);
        wait_result("allneg", 16'hFFFF, 10'd2);
    endtask

    task automatic test_tie();
        do_start(8'd3);
        for (int i = 0; i < 3; i++) beat(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        wait_result("tie", 16'h0100, 10'd0);
    endtask

    task automatic test_len_zero();
        do_start(8'd0);
        n_tests++;
        if (max_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_done: max_valid=%b in_ready=%b expected 1 0", max_valid, in_ready);
        end
        n_tests++;
        if (max_out !== 16'h8000) begin
            n_fail++;
            $display("FAIL len0_max: max_out=%h expected 8000", max_out);
        end
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            len   = 8'd2;
            tick();
            n_tests++;
            if (max_valid !== 1'b1 || max_out !== 16'h8000 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL len0_stall%0d: valid=%b max_out=%h in_ready=%b expected 1 8000 0", c, max_valid, max_out, in_ready);
            end
        end
        // start in the same cycle as the handshake must be ignored.
        start     = 1'b1;
        len       = 8'd3;
        max_ready = 1'b1;
        tick();
        start     = 1'b0;
        max_ready = 1'b0;
        n_tests++;
        if (max_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_hs_start: max_valid=%b in_ready=%b expected 0 0", max_valid, in_ready);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_idle: in_ready=%b expected 0", in_ready);
        end
    endtask

    task automatic test_gaps_and_reset();
        logic [15:0] gv [4][4];
        gv[0] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        gv[1] = '{16'h0050, 16'h0001, 16'h0002, 16'h0003};
        gv[2] = '{16'h0004, 16'h0060, 16'h0005, 16'h0006};
        gv[3] = '{16'h0007, 16'h0008, 16'h0009, 16'h0055};
        do_start(8'd4);
        for (int b = 0; b < 4; b++) begin
            beat(gv[b][0], gv[b][1], gv[b][2], gv[b][3]);
            if (b < 3) begin
                // Idle cycle with poison data that must not be consumed.
                a_inp0 = 16'h7FFF;
                a_inp1 = 16'h7FFF;
                a_inp2 = 16'h7FFF;
                a_inp3 = 16'h7FFF;
                tick();
            end
        end
        // Extra data after the last beat must be refused.
        a_inp0   = 16'h7FFF;
        a_inp1   = 16'h7FFF;
        a_inp2   = 16'h7FFF;
        a_inp3   = 16'h7FFF;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps_extra%0d: in_ready=%b expected 0", c, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        wait_result("gaps", 16'h0060, 10'd9);

        // Second row abandoned by reset mid-row.
        do_start(8'd3);
        beat(16'h7000, 16'h0000, 16'h0000, 16'h0000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || max_valid !== 1'b0 || max_out !== 16'h8000) begin
            n_fail++;
            $display("FAIL midrst: in_ready=%b max_valid=%b max_out=%h expected 0 0 8000", in_ready, max_valid, max_out);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_tests++;
        if (max_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: max_valid=%b in_ready=%b expected 0 0", max_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_start(8'd1);
        beat(16'h7000, 16'h0001, 16'h0002, 16'h0003);
        wait_result("b2b_first", 16'h7000, 10'd0);
        do_start(8'd2);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: in_ready=%b expected 1", in_ready);
        end
        beat(16'h0011, 16'h0012, 16'hFFFF, 16'h0001);
        beat(16'h0003, 16'h0013, 16'h8000, 16'h0000);
        wait_result("b2b_second", 16'h0013, 10'd5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_negative();
        test_tie();
        test_len_zero();
        test_gaps_and_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/softmax_max_reduce.md
# softmax_max_reduce

Streaming signed fixed-point max-reduction unit for the softmax datapath. It consumes a row of scores four lanes per beat and produces the single row maximum. That maximum is the scalar operand broadcast into the four-lane subtract stage (mode 6), which computes each score minus the max. The block sits immediately upstream of that subtract stage and writes the value it reads.

## Interface
Parameters:
- DATAWIDTH, 16, lane width; two's-complement signed fixed point.
- NUM, 4, lanes per beat; fixed at 4.
- LEN_W, 8, width of the beat-count input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a row; sampled only in IDLE.
- len  in  LEN_W  beats in the row; sampled with start.
- in_valid  in  1  lane data valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_inp0..a_inp3  in  DATAWIDTH each  lane scores.
- max_valid  out  1  row maximum available.
- max_ready  in  1  consumer takes max_out.
- max_out  out  DATAWIDTH  row maximum, feeds b_inp of the subtract stage.
- max_idx  out  LEN_W+2  flat index of the maximum; present only with MAX_REDUCE_ARGMAX_EN.

## Operation
- All comparisons are signed two's complement over DATAWIDTH bits.
- The running max initialises to NEG_MAX (16'h8000) at each accepted start.
- States and transitions:
  - IDLE → ACCUM on start with len≠0. Latch len into the beat counter.
  - IDLE → DONE on start with len=0. max_out=16'h8000, max_idx=0.
  - ACCUM: in_ready=1. A beat is accepted when in_valid & in_ready. Stage 1 registers the 4-lane max and its lane index. The counter decrements per accepted beat. On the last beat, go to DRAIN.
  - DRAIN: in_ready=0. One cycle for stage 2 to fold the final stage-1 result. → DONE.
  - DONE: max_valid=1; max_out and max_idx are stable. On max_valid & max_ready → IDLE.
- Stage 2 updates the running max only if the stage-1 value is strictly greater. Ties therefore keep the earlier beat; within a beat, ties resolve to the lowest lane.
- max_idx = beat_number*4 + lane, where the first beat of the row is 0.
- start outside IDLE is ignored, including in the same cycle as the DONE handshake.
- Reset mid-row abandons the row. All state returns to the reset values, and no partial result is emitted.
- Beats presented while in_ready=0 are not consumed. No data is dropped or duplicated under arbitrary in_valid gaps.

## Timing
- Reset values: in_ready=0, max_valid=0, max_out=16'h8000, max_idx=0, state=IDLE.
- The start accept edge moves to ACCUM; in_ready is high in the next cycle.
- Last beat accepted at edge N: state=DRAIN after N, DONE after N+1. max_valid is first high in the cycle following edge N+1, so latency is 2 cycles from the last beat.
- Throughput: one beat per cycle in ACCUM. Row overhead is 1 (start) + 1 (DRAIN) + ≥1 (DONE) cycles.
- max_out is registered and holds through DONE until the handshake edge. It is not cleared on returning to IDLE; it reinitialises on the next start.

## Configuration
- MAX_REDUCE_ARGMAX_EN defined:
  - max_idx port exists.
  - Lane index and beat number are tracked through both stages.
- MAX_REDUCE_ARGMAX_EN undefined:
  - No max_idx port and no index registers.
  - max_out behaviour is cycle-identical.

## Structure
- Shared package softmax_pkg holds:
  - DATAWIDTH and NUM constants.
  - NEG_MAX = 16'h8000.
  - The state enum (IDLE, ACCUM, DRAIN, DONE).
- Sub-module max4_tree: combinational 4-input signed max with a 2-bit lowest-lane index. It is instantiated once for stage 1.

## Test plan
- Reset release, then start with len=2.
  - Beats {1,5,3,2} then {4,0,7,6} (hex 0x0001… style values).
  - Expect max_out=0x0007, max_idx=6.
  - max_valid is high 2 cycles after the second beat.
- All-negative row, len=1, beat {0xFFF0,0xFF00,0xFFFF,0x8001}.
  - Expect max_out=0xFFFF, max_idx=2.
- Tie across beats, len=3, every lane 0x0100.
  - Expect max_out=0x0100, max_idx=0.
- start with len=0.
  - DONE is reached the cycle after start.
  - Expect max_out=0x8000.
  - Hold max_ready=0 for 5 cycles: outputs stay stable, and a start during DONE is ignored.
- len=4 with in_valid toggling every other cycle.
  - Exactly 4 beats are accepted and the result is correct.
  - Then assert rst mid-row in a second row: in_ready and max_valid drop immediately and no result appears.
- Back-to-back rows.
  - Handshake in DONE, start the next cycle.
  - The second result is independent of the first; a larger first-row max must not leak into the second row.
